main_memory_interface: RTL and testbench
========================================

# main_memory_interface

Main-memory slave serving the microcoded control unit. It consumes the level-held RD/WR strobes driven from the MIR, together with the address and write-data buses from the datapath. It performs a word access on an internal memory array after a programmable number of wait states, then returns a one-cycle ACK. That ACK is what lets the control store address incrementer advance past a memory microinstruction.

## Interface
Parameters:
- DATAWIDTH_BUS, 32, width of address, write-data and read-data buses.
- ADDR_WORDS_LOG2, 10, log2 of array depth in 32-bit words (default 1024 words).
- WAIT_STATES, 2, extra cycles before access; legal range 0..15.

Ports:
- Main_Memory_Interface_CLOCK_50  in  1  single system clock, rising edge.
- Main_Memory_Interface_RESET_InHigh  in  1  reset, asynchronous, active-high.
- Main_Memory_Interface_RD  in  1  read request level, from MIR RD field.
- Main_Memory_Interface_WR  in  1  write request level, from MIR WR field.
- Main_Memory_Interface_ADDRESS_InBUS  in  DATAWIDTH_BUS  byte address (datapath bus A).
- Main_Memory_Interface_data_InBUS  in  DATAWIDTH_BUS  write data (datapath bus B).
- Main_Memory_Interface_data_OutBUS  out  DATAWIDTH_BUS  registered read data, to datapath bus C.
- Main_Memory_Interface_ACK  out  1  registered one-cycle completion pulse, to the control unit ACK input.
- Main_Memory_Interface_ERROR  out  1  registered; set with ACK on a faulted access, cleared at the next accepted request.

## Operation
- States: IDLE, BUSY, DONE. Encoding is free.
- IDLE:
  - If RD or WR is high at a clock edge, the block latches address, write data and op (RD, WR, or both) into internal registers.
  - It loads the wait counter with WAIT_STATES, clears ERROR and moves to BUSY.
- BUSY:
  - At each edge with counter != 0, the counter decrements.
  - At the edge with counter == 0, the access executes, ACK is set to 1 and the state moves to DONE.
- Access rules at that edge:
  - Word index = latched address[ADDR_WORDS_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*2^ADDR_WORDS_LOG2 bytes.
  - Read: data_OutBUS <= array[index].
  - Write: array[index] <= latched data. data_OutBUS is unchanged.
  - Misaligned (latched address[1:0] != 0): no array write, data_OutBUS unchanged, ERROR <= 1, ACK still pulses.
  - RD and WR both high at acceptance: illegal. Same handling as misaligned: ERROR, no write, data_OutBUS unchanged.
- DONE: ACK is high for exactly this cycle. The next edge clears ACK and returns to IDLE. RD/WR are ignored in DONE.
- RD/WR changing or dropping while BUSY is ignored. The latched request completes.
- The array is not reset. Contents persist across reset.

## Timing
- Reset (asynchronous): state = IDLE, counter = 0, ACK = 0, ERROR = 0, data_OutBUS = 0. Latched address, data and op are cleared to 0.
- Reset mid-BUSY aborts the access with no array write and no ACK.
- Latency: request sampled at edge k, ACK high from edge k+WAIT_STATES+1 to edge k+WAIT_STATES+2. Read data is valid on data_OutBUS from the same edge ACK rises and holds until the next completed read.
- Example, WAIT_STATES=0: sample at k, ACK during cycle k+1..k+2, IDLE re-entered at k+2, earliest next sample at edge k+3.
- Back-to-back requests: a request held continuously across ACK is treated as a new request at the first IDLE edge. The MIR must have loaded the next microword by then; consecutive RD microinstructions therefore each get their own ACK.
- Throughput: one access per WAIT_STATES+3 cycles maximum.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then with WAIT_STATES=2: write 0xDEADBEEF to 0x0000_0010 (WR high at edge 1) -> ACK high cycle 4 only, ERROR=0; then read 0x10 -> data_OutBUS=0xDEADBEEF at ACK rise.
- WAIT_STATES=0: two back-to-back reads with RD held high, at 0x4 (preloaded 0x11111111) then 0x8 (0x22222222) -> two separate ACK pulses 3 cycles apart, data changes on each ACK.
- Misaligned write to 0x0000_0013 -> ACK pulses, ERROR=1, word 0x10 unchanged; next aligned read clears ERROR to 0.
- RD and WR both high -> ERROR=1, no write, data_OutBUS keeps previous read value.
- Wrap: ADDR_WORDS_LOG2=10, write 0xA5A5A5A5 to 0x0000_1004 -> read of 0x0000_0004 returns 0xA5A5A5A5.
- Assert RESET mid-BUSY on a write of 0x12345678 to 0x20 -> ACK stays 0, outputs 0, subsequent read of 0x20 returns prior contents.

Source files
------------

// File: rtl/main_memory_interface.sv
// Main-memory slave: word read/write on an internal array for the microcoded control unit.
// Latency: request sampled at edge k, ACK pulses for one cycle from edge k+WAIT_STATES+1.
// Backpressure: none; RD/WR are ignored while BUSY/DONE, so at most one access per WAIT_STATES+3 cycles.
module main_memory_interface #(
  parameter int DATAWIDTH_BUS   = 32,
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int WAIT_STATES     = 2
) (
  input  logic                     Main_Memory_Interface_CLOCK_50,
  input  logic                     Main_Memory_Interface_RESET_InHigh,
  input  logic                     Main_Memory_Interface_RD,
  input  logic                     Main_Memory_Interface_WR,
  input  logic [DATAWIDTH_BUS-1:0] Main_Memory_Interface_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] Main_Memory_Interface_data_InBUS,
  output logic [DATAWIDTH_BUS-1:0] Main_Memory_Interface_data_OutBUS,
  output logic                     Main_Memory_Interface_ACK,
  output logic                     Main_Memory_Interface_ERROR
);

  // Byte address bits that matter: word index plus the two alignment bits.
  localparam int ADDR_LSBS = ADDR_WORDS_LOG2 + 2;
  localparam int DEPTH     = 1 << ADDR_WORDS_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      state;
  logic [3:0]                  wait_cnt;
  logic [ADDR_LSBS-1:0]        lat_addr;
  logic [DATAWIDTH_BUS-1:0]    lat_data;
  logic                        lat_rd;
  logic                        lat_wr;
  logic [DATAWIDTH_BUS-1:0]    mem [DEPTH];

  logic [ADDR_WORDS_LOG2-1:0]  word_idx;
  logic                        fault;
  logic                        exec;
  logic                        mem_we;

  // Upper address bits are don't-care: the array aliases modulo its byte size.
  if (DATAWIDTH_BUS > ADDR_LSBS) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^Main_Memory_Interface_ADDRESS_InBUS[DATAWIDTH_BUS-1:ADDR_LSBS];
  end

  assign word_idx = lat_addr[ADDR_LSBS-1:2];
  // Misaligned or simultaneous RD+WR: complete with ERROR, touch nothing.
  assign fault    = (lat_addr[1:0] != 2'b00) || (lat_rd && lat_wr);
  assign exec     = (state == BUSY) && (wait_cnt == 4'd0);
  assign mem_we   = exec && lat_wr && !fault;

  // Array write port; deliberately not reset so contents survive reset.
  always_ff @(posedge Main_Memory_Interface_CLOCK_50) begin
    if (mem_we) begin
      mem[word_idx] <= lat_data;
    end
  end

  // Request FSM: accept in IDLE, count wait states in BUSY, pulse ACK in DONE.
  always_ff @(posedge Main_Memory_Interface_CLOCK_50 or posedge Main_Memory_Interface_RESET_InHigh) begin
    if (Main_Memory_Interface_RESET_InHigh) begin
      state                            <= IDLE;
      wait_cnt                         <= 4'd0;
      lat_addr                         <= '0;
      lat_data                         <= '0;
      lat_rd                           <= 1'b0;
      lat_wr                           <= 1'b0;
      Main_Memory_Interface_data_OutBUS <= '0;
      Main_Memory_Interface_ACK        <= 1'b0;
      Main_Memory_Interface_ERROR      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Main_Memory_Interface_RD || Main_Memory_Interface_WR) begin
            lat_addr                    <= Main_Memory_Interface_ADDRESS_InBUS[ADDR_LSBS-1:0];
            lat_data                    <= Main_Memory_Interface_data_InBUS;
            lat_rd                      <= Main_Memory_Interface_RD;
            lat_wr                      <= Main_Memory_Interface_WR;
            wait_cnt                    <= 4'(WAIT_STATES);
            Main_Memory_Interface_ERROR <= 1'b0;
            state                       <= BUSY;
          end
        end
        BUSY: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            Main_Memory_Interface_ACK <= 1'b1;
            if (fault) begin
              Main_Memory_Interface_ERROR <= 1'b1;
            end else if (lat_rd) begin
              Main_Memory_Interface_data_OutBUS <= mem[word_idx];
            end
            state <= DONE;
          end
        end
        DONE: begin
          Main_Memory_Interface_ACK <= 1'b0;
          state                     <= IDLE;
        end
        default: begin
          Main_Memory_Interface_ACK <= 1'b0;
          state                     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_interface.sv
// Bench for main_memory_interface: two instances (WAIT_STATES=2 and 0) against a word-array model.
// Latency checked as cycles from request sample to ACK; outputs sampled 1ns after the rising edge.
// Instance under test is chosen by sel; the other sees RD/WR held low.
module tb_main_memory_interface;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        sel = 1'b0;

  logic [31:0] dout_a, dout_b;
  logic        ack_a, ack_b, err_a, err_b;
  logic [31:0] dout;
  logic        ack, err;

  int checks = 0;
  int fails  = 0;

  // Reference state: one word array, read register and error flag per instance.
  logic [31:0] model_mem [2][1024];
  logic [31:0] model_dout [2];
  logic        model_err [2];

  always #5 clk = ~clk;

  assign dout = sel ? dout_b : dout_a;
  assign ack  = sel ? ack_b  : ack_a;
  assign err  = sel ? err_b  : err_a;

  main_memory_interface #(.DATAWIDTH_BUS(32), .ADDR_WORDS_LOG2(10), .WAIT_STATES(2)) dut_a (
    .Main_Memory_Interface_CLOCK_50     (clk),
    .Main_Memory_Interface_RESET_InHigh (rst),
    .Main_Memory_Interface_RD           (rd & ~sel),
    .Main_Memory_Interface_WR           (wr & ~sel),
    .Main_Memory_Interface_ADDRESS_InBUS(addr),
    .Main_Memory_Interface_data_InBUS   (wdata),
    .Main_Memory_Interface_data_OutBUS  (dout_a),
    .Main_Memory_Interface_ACK          (ack_a),
    .Main_Memory_Interface_ERROR        (err_a)
  );

  main_memory_interface #(.DATAWIDTH_BUS(32), .ADDR_WORDS_LOG2(10), .WAIT_STATES(0)) dut_b (
    .Main_Memory_Interface_CLOCK_50     (clk),
    .Main_Memory_Interface_RESET_InHigh (rst),
    .Main_Memory_Interface_RD           (rd & sel),
    .Main_Memory_Interface_WR           (wr & sel),
    .Main_Memory_Interface_ADDRESS_InBUS(addr),
    .Main_Memory_Interface_data_InBUS   (wdata),
    .Main_Memory_Interface_data_OutBUS  (dout_b),
    .Main_Memory_Interface_ACK          (ack_b),
    .Main_Memory_Interface_ERROR        (err_b)
  );

  // One complete access on the selected instance, checked for latency, ERROR, data and ACK width.
  task automatic do_access(input string name, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
    int n;
    int s;
    int ws;
    int idx;
    logic bad;
    s   = sel ? 1 : 0;
    ws  = sel ? 0 : 2;
    idx = int'(a[11:2]);
    bad = (a[1:0] != 2'b00) || (r && w);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    checks++;
    if (err !== 1'b0 || ack !== 1'b0) begin
      $display("FAIL %s accept: err=%b ack=%b, required err=0 ack=0", name, err, ack);
      fails++;
    end
    n = 0;
    while (ack !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != ws + 1) begin
      $display("FAIL %s latency: ack after %0d cycles, required %0d", name, n, ws + 1);
      fails++;
    end
    if (bad) begin
      model_err[s] = 1'b1;
    end else begin
      model_err[s] = 1'b0;
      if (r) model_dout[s] = model_mem[s][idx];
      else   model_mem[s][idx] = d;
    end
    checks++;
    if (err !== model_err[s]) begin
      $display("FAIL %s error: got %b, required %b", name, err, model_err[s]);
      fails++;
    end
    checks++;
    if (dout !== model_dout[s]) begin
      $display("FAIL %s data: got %h, required %h", name, dout, model_dout[s]);
      fails++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0) begin
      $display("FAIL %s ack_width: ack=%b one cycle later, required 0", name, ack);
      fails++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    checks++;
    if (dout_a !== 32'h0 || ack_a !== 1'b0 || err_a !== 1'b0 ||
        dout_b !== 32'h0 || ack_b !== 1'b0 || err_b !== 1'b0) begin
      $display("FAIL reset: a=%h/%b/%b b=%h/%b/%b, required all zero",
               dout_a, ack_a, err_a, dout_b, ack_b, err_b);
      fails++;
    end
    for (int s = 0; s < 2; s++) begin
      model_dout[s] = 32'h0;
      model_err[s]  = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    sel = 1'b0;
    do_access("basic_wr", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    do_access("basic_rd", 1'b1, 1'b0, 32'h0000_0010, 32'h0);
  endtask

  // Give words 0..15 of both arrays known contents for the reads that follow.
  task automatic test_fill;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 16; i++) begin
        do_access("fill", 1'b0, 1'b1, 32'(i * 4), $urandom);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n1;
    int n2;
    sel = 1'b1;
    do_access("b2b_pre4", 1'b0, 1'b1, 32'h4, 32'h1111_1111);
    do_access("b2b_pre8", 1'b0, 1'b1, 32'h8, 32'h2222_2222);
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; addr = 32'h4;
    @(posedge clk);
    #1;
    n1 = 0;
    while (ack !== 1'b1 && n1 < 40) begin
      @(posedge clk); #1; n1++;
    end
    checks++;
    if (n1 != 1 || dout !== 32'h1111_1111) begin
      $display("FAIL b2b_first: latency %0d data %h, required 1 and 11111111", n1, dout);
      fails++;
    end
    @(negedge clk);
    addr = 32'h8;
    @(posedge clk);
    #1;
    n2 = 1;
    checks++;
    if (ack !== 1'b0) begin
      $display("FAIL b2b_gap: ack=%b, required 0", ack);
      fails++;
    end
    while (ack !== 1'b1 && n2 < 40) begin
      @(posedge clk); #1; n2++;
    end
    @(negedge clk);
    rd = 1'b0;
    checks++;
    if (n2 != 3 || dout !== 32'h2222_2222) begin
      $display("FAIL b2b_second: spacing %0d data %h, required 3 and 22222222", n2, dout);
      fails++;
    end
    model_dout[1] = 32'h2222_2222;
    model_err[1]  = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0) begin
      $display("FAIL b2b_end: ack=%b, required 0", ack);
      fails++;
    end
  endtask

  task automatic test_misaligned;
    sel = 1'b0;
    do_access("mis_wr", 1'b0, 1'b1, 32'h0000_0013, 32'h5555_AAAA);
    do_access("mis_rd10", 1'b1, 1'b0, 32'h0000_0010, 32'h0);
  endtask

  task automatic test_illegal;
    sel = 1'b0;
    do_access("ill_pre", 1'b1, 1'b0, 32'h0000_000C, 32'h0);
    do_access("ill_both", 1'b1, 1'b1, 32'h0000_0010, 32'h0BAD_0BAD);
    do_access("ill_rd10", 1'b1, 1'b0, 32'h0000_0010, 32'h0);
  endtask

  task automatic test_wrap;
    sel = 1'b0;
    do_access("wrap_wr", 1'b0, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5);
    do_access("wrap_rd", 1'b1, 1'b0, 32'h0000_0004, 32'h0);
  endtask

  task automatic test_reset_mid_busy;
    sel = 1'b0;
    do_access("rmb_pre", 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    @(negedge clk);
    wr = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || dout !== 32'h0) begin
      $display("FAIL rmb_reset: ack=%b err=%b data=%h, required 0/0/0", ack, err, dout);
      fails++;
    end
    for (int s = 0; s < 2; s++) begin
      model_dout[s] = 32'h0;
      model_err[s]  = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ack !== 1'b0) begin
        $display("FAIL rmb_hold: ack=%b during reset, required 0", ack);
        fails++;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    do_access("rmb_rd", 1'b1, 1'b0, 32'h0000_0020, 32'h0);
  endtask

  task automatic test_random;
    int kind;
    logic [31:0] a;
    for (int i = 0; i < 80; i++) begin
      sel  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      a    = (32'($urandom_range(0, 15)) << 12) | (32'($urandom_range(0, 15)) << 2);
      if (kind <= 3)      do_access("rnd_rd", 1'b1, 1'b0, a, 32'h0);
      else if (kind <= 7) do_access("rnd_wr", 1'b0, 1'b1, a, $urandom);
      else if (kind == 8) do_access("rnd_mis", 1'($urandom_range(0, 1)), 1'b1,
                                    a | 32'($urandom_range(1, 3)), $urandom);
      else                do_access("rnd_both", 1'b1, 1'b1, a, $urandom);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_fill;
    test_back_to_back;
    test_misaligned;
    test_illegal;
    test_wrap;
    test_reset_mid_busy;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
